// File: rtl/mem_bus_pkg.sv
// Shared state encoding and default bus geometry for the memory bus initiator.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      MM_INIT,
      MM_IDLE,
      MM_READ,
      MM_WRITE
   } mm_state_e;

   localparam int MM_AW = 8;
   localparam int MM_DW = 32;
   localparam int MM_LW = 4;

endpackage

// File: rtl/mem_master.sv
// Burst initiator for the single-port word memory: registered strobes, pipelined read return.
// Optional MEM_MASTER_INIT_CLEAR_EN: sweep INIT_VALUE over the whole memory after reset.
module mem_master
   import mem_bus_pkg::*;
#(
   parameter int AW = MM_AW,
   parameter int DW = MM_DW,
   parameter int LW = MM_LW,
   parameter logic [DW-1:0] INIT_VALUE = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic          wdata_valid,
   input  logic [DW-1:0] wdata,
   output logic          wdata_ready,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic          done,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic          mem_ce,
   output logic          mem_sel,
   output logic          mem_pwrite,
   output logic [DW-1:0] mem_wr_data,
   input  logic [DW-1:0] mem_rd_data
);

   mm_state_e     state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] remaining_q, remaining_d;
   logic          lastBeat_q, lastBeat_d;
   logic [AW-1:0] memAddr_q, memAddr_d;
   logic          memCe_q, memCe_d;
   logic          memSel_q, memSel_d;
   logic          memPwrite_q, memPwrite_d;
   logic [DW-1:0] memWrData_q, memWrData_d;
   logic          rspValid_q, rspValid_d;
   logic          rspLast_q, rspLast_d;
   logic          done_q, done_d;

   // addr_q always holds the address of the next beat to issue; lastBeat_q tags the beat on the bus.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      lastBeat_d  = 1'b0;
      memAddr_d   = memAddr_q;
      memCe_d     = 1'b0;
      memSel_d    = 1'b1;
      memPwrite_d = 1'b0;
      memWrData_d = memWrData_q;
      rspValid_d  = memCe_q && !memPwrite_q;
      rspLast_d   = memCe_q && !memPwrite_q && lastBeat_q;
      done_d      = memCe_q && lastBeat_q;

      case (state_q)
         MM_INIT: begin
            memCe_d     = 1'b1;
            memSel_d    = 1'b0;
            memPwrite_d = 1'b1;
            memAddr_d   = addr_q;
            memWrData_d = INIT_VALUE;
            addr_d      = addr_q + 1'b1;
            if (addr_q == {AW{1'b1}}) begin
               state_d = MM_IDLE;
            end
         end
         MM_IDLE: begin
            if (cmd_valid) begin
               remaining_d = cmd_len;
               addr_d      = cmd_addr;
               if (cmd_write) begin
                  state_d = MM_WRITE;
               end else begin
                  // The first read beat goes out on the handshake edge itself.
                  state_d     = MM_READ;
                  memCe_d     = 1'b1;
                  memSel_d    = 1'b0;
                  memAddr_d   = cmd_addr;
                  addr_d      = cmd_addr + 1'b1;
                  lastBeat_d  = (cmd_len == '0);
               end
            end
         end
         MM_READ: begin
            if (remaining_q == '0) begin
               state_d = MM_IDLE;
            end else begin
               memCe_d     = 1'b1;
               memSel_d    = 1'b0;
               memAddr_d   = addr_q;
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               lastBeat_d  = (remaining_q == LW'(1));
            end
         end
         MM_WRITE: begin
            if (wdata_valid) begin
               memCe_d     = 1'b1;
               memSel_d    = 1'b0;
               memPwrite_d = 1'b1;
               memAddr_d   = addr_q;
               memWrData_d = wdata;
               addr_d      = addr_q + 1'b1;
               lastBeat_d  = (remaining_q == '0);
               if (remaining_q == '0) begin
                  state_d = MM_IDLE;
               end else begin
                  remaining_d = remaining_q - 1'b1;
               end
            end
         end
         default: state_d = MM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef MEM_MASTER_INIT_CLEAR_EN
         state_q     <= MM_INIT;
`else
         state_q     <= MM_IDLE;
`endif
         addr_q      <= '0;
         remaining_q <= '0;
         lastBeat_q  <= 1'b0;
         memAddr_q   <= '0;
         memCe_q     <= 1'b0;
         memSel_q    <= 1'b1;
         memPwrite_q <= 1'b0;
         memWrData_q <= '0;
         rspValid_q  <= 1'b0;
         rspLast_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         lastBeat_q  <= lastBeat_d;
         memAddr_q   <= memAddr_d;
         memCe_q     <= memCe_d;
         memSel_q    <= memSel_d;
         memPwrite_q <= memPwrite_d;
         memWrData_q <= memWrData_d;
         rspValid_q  <= rspValid_d;
         rspLast_q   <= rspLast_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready   = (state_q == MM_IDLE) && !rst;
   assign wdata_ready = (state_q == MM_WRITE);
   assign busy        = (state_q != MM_IDLE);
   assign rsp_valid   = rspValid_q;
   assign rsp_data    = mem_rd_data;
   assign rsp_last    = rspLast_q;
   assign done        = done_q;
   assign mem_addr    = memAddr_q;
   assign mem_ce      = memCe_q;
   assign mem_sel     = memSel_q;
   assign mem_pwrite  = memPwrite_q;
   assign mem_wr_data = memWrData_q;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master paired with a registered-read memory model; read returns checked by a scoreboard.
module tb_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic        wdata_valid = 1'b0;
   logic [31:0] wdata = '0;
   logic        wdata_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        done;
   logic        busy;
   logic [7:0]  mem_addr;
   logic        mem_ce;
   logic        mem_sel;
   logic        mem_pwrite;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data = '0;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        expQ[$];
   exp_t        expItem;
   logic [31:0] memArr [256] = '{default: 32'h0};
   logic [31:0] shadow [256] = '{default: 32'h0};
   int          total = 0;
   int          bad = 0;
   int          doneCount = 0;
   int          rspCount = 0;

   localparam logic [31:0] FILL = 32'hA5A5A5A5;

   mem_master #(.AW(8), .DW(32), .LW(4), .INIT_VALUE(FILL)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .done(done), .busy(busy),
      .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_sel(mem_sel),
      .mem_pwrite(mem_pwrite), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   // Memory model: access only when ce && !sel, read data registered.
   always @(posedge clk) begin
      if (mem_ce && !mem_sel) begin
         if (mem_pwrite) memArr[mem_addr] <= mem_wr_data;
         else            mem_rd_data <= memArr[mem_addr];
      end
   end

   // Scoreboard consumer: every response beat must match the oldest expectation.
   always @(negedge clk) begin
      if (done) doneCount++;
      if (rsp_valid) begin
         rspCount++;
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL rsp_unexpected got data=%h last=%b, required no beat", rsp_data, rsp_last);
         end else begin
            expItem = expQ.pop_front();
            if (rsp_data !== expItem.data || rsp_last !== expItem.last) begin
               bad++;
               $display("[TB] FAIL rsp_beat got data=%h last=%b, required data=%h last=%b",
                        rsp_data, rsp_last, expItem.data, expItem.last);
            end
         end
      end
   end

   // Offers a command and returns #1 after its handshake edge; read expectations come from the shadow copy.
   task automatic doCmd(input logic w, input logic [7:0] a, input logic [3:0] l);
      bit seen = 0;
      logic [7:0] ad;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (cmd_ready) seen = 1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      total++;
      if (!seen) begin
         bad++;
         $display("[TB] FAIL cmd_handshake got no cmd_ready in 400 cycles, required acceptance");
      end else if (!w) begin
         ad = a;
         for (int i = 0; i <= int'(l); i++) begin
            expQ.push_back('{data: shadow[ad], last: (i == int'(l))});
            ad = ad + 8'd1;
         end
      end
   endtask

   task automatic writeBeats(input logic [7:0] a, input logic [3:0] l, input logic [31:0] seed);
      logic [7:0] ad = a;
      for (int i = 0; i <= int'(l); i++) begin
         wdata_valid = 1'b1;
         wdata = seed + 32'(i);
         shadow[ad] = seed + 32'(i);
         ad = ad + 8'd1;
         @(posedge clk);
         #1;
      end
      wdata_valid = 1'b0;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 50 && (busy || expQ.size() != 0); i++) begin
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic fillShadowIfInit();
`ifdef MEM_MASTER_INIT_CLEAR_EN
      for (int i = 0; i < 256; i++) shadow[i] = FILL;
`endif
   endtask

   task automatic test_reset();
      int lowCycles = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_cmd_ready got %b, required 0", cmd_ready);
      end
      total++;
      if ({mem_ce, mem_sel, mem_pwrite, rsp_valid, rsp_last, done} !== 6'b010000) begin
         bad++;
         $display("[TB] FAIL reset_strobes got ce/sel/pw/rv/rl/dn=%b, required 010000",
                  {mem_ce, mem_sel, mem_pwrite, rsp_valid, rsp_last, done});
      end
      total++;
      if (mem_addr !== 8'h00 || mem_wr_data !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_bus got addr=%h wdata=%h, required 00 00000000", mem_addr, mem_wr_data);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef MEM_MASTER_INIT_CLEAR_EN
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
         lowCycles++;
      end
      total++;
      if (lowCycles != 256) begin
         bad++;
         $display("[TB] FAIL init_sweep_len got %0d cycles, required 256", lowCycles);
      end
      fillShadowIfInit();
      @(posedge clk);
      #1;
`else
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || lowCycles != 0) begin
         bad++;
         $display("[TB] FAIL reset_idle got busy=%b ready=%b, required 0 1", busy, cmd_ready);
      end
      @(posedge clk);
      #1;
`endif
   endtask

   task automatic test_init();
      doCmd(1'b0, 8'h7F, 4'd0);
      waitIdle();
   endtask

   task automatic test_single();
      doCmd(1'b1, 8'h10, 4'd0);
      wdata_valid = 1'b1;
      wdata = 32'hDEADBEEF;
      shadow[8'h10] = 32'hDEADBEEF;
      @(negedge clk);
      total++;
      if (wdata_ready !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_wready got ready=%b busy=%b, required 1 1", wdata_ready, busy);
      end
      @(posedge clk);
      #1;
      wdata_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_ce, mem_sel, mem_pwrite} !== 3'b101 || mem_addr !== 8'h10 || mem_wr_data !== 32'hDEADBEEF) begin
         bad++;
         $display("[TB] FAIL single_wbeat got ce/sel/pw=%b addr=%h data=%h, required 101 10 deadbeef",
                  {mem_ce, mem_sel, mem_pwrite}, mem_addr, mem_wr_data);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (done !== 1'b1 || mem_ce !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_wdone got done=%b ce=%b, required 1 0", done, mem_ce);
      end
      waitIdle();
      doCmd(1'b0, 8'h10, 4'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_last !== 1'b1 || done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL single_read got v=%b data=%h last=%b done=%b, required 1 deadbeef 1 1",
                  rsp_valid, rsp_data, rsp_last, done);
      end
      waitIdle();
   endtask

   task automatic test_wrap();
      logic [7:0] expAddr [4];
      int startCount;
      expAddr[0] = 8'hFE; expAddr[1] = 8'hFF; expAddr[2] = 8'h00; expAddr[3] = 8'h01;
      doCmd(1'b1, 8'hFE, 4'd3);
      writeBeats(8'hFE, 4'd3, 32'h1234_0000);
      waitIdle();
      startCount = rspCount;
      doCmd(1'b0, 8'hFE, 4'd3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (mem_ce !== 1'b1 || mem_sel !== 1'b0 || mem_addr !== expAddr[i]) begin
            bad++;
            $display("[TB] FAIL wrap_addr%0d got ce=%b sel=%b addr=%h, required 1 0 %h",
                     i, mem_ce, mem_sel, mem_addr, expAddr[i]);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1 || mem_ce !== 1'b0) begin
         bad++;
         $display("[TB] FAIL wrap_done got done=%b ce=%b, required 1 0", done, mem_ce);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (rspCount - startCount != 4) begin
         bad++;
         $display("[TB] FAIL wrap_beats got %0d responses, required 4", rspCount - startCount);
      end
      waitIdle();
   endtask

   task automatic test_bubble();
      logic pattern [5];
      logic [7:0] beatAddr = 8'h20;
      int beatIdx = 0;
      pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1; pattern[3] = 1'b1; pattern[4] = 1'b0;
      doCmd(1'b1, 8'h20, 4'd2);
      for (int i = 0; i < 5; i++) begin
         wdata_valid = pattern[i];
         wdata = 32'hC0DE_0000 + 32'(beatIdx);
         if (pattern[i]) begin
            shadow[8'h20 + 8'(beatIdx)] = wdata;
            beatIdx++;
         end
         @(negedge clk);
         if (i >= 1) begin
            total++;
            if (mem_ce !== pattern[i-1] || mem_sel !== !pattern[i-1] ||
                (pattern[i-1] && mem_addr !== beatAddr)) begin
               bad++;
               $display("[TB] FAIL bubble_cycle%0d got ce=%b sel=%b addr=%h, required ce=%b addr=%h",
                        i, mem_ce, mem_sel, mem_addr, pattern[i-1], beatAddr);
            end
            if (pattern[i-1]) beatAddr = beatAddr + 8'd1;
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bubble_done got %b, required 1", done);
      end
      waitIdle();
      doCmd(1'b0, 8'h20, 4'd2);
      waitIdle();
   endtask

   task automatic test_reset_mid();
      int doneBefore;
      doCmd(1'b0, 8'h40, 4'd3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (mem_ce !== 1'b0 || mem_sel !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_bus got ce=%b sel=%b rv=%b, required 0 1 0", mem_ce, mem_sel, rsp_valid);
      end
      expQ.delete();
      doneBefore = doneCount;
      for (int i = 0; i < 300 && !cmd_ready; i++) begin
         @(posedge clk);
         #1;
      end
      repeat (5) @(posedge clk);
      #1;
      fillShadowIfInit();
      total++;
      if (doneCount != doneBefore) begin
         bad++;
         $display("[TB] FAIL midreset_done got %0d pulses, required 0", doneCount - doneBefore);
      end
   endtask

   task automatic test_back_to_back();
      logic expReady [3];
      expReady[0] = 1'b0; expReady[1] = 1'b0; expReady[2] = 1'b1;
      doCmd(1'b0, 8'h50, 4'd1);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'h10;
      cmd_len   = 4'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (cmd_ready !== expReady[i]) begin
            bad++;
            $display("[TB] FAIL b2b_ready%0d got %b, required %b", i, cmd_ready, expReady[i]);
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      expQ.push_back('{data: shadow[8'h10], last: 1'b0});
      expQ.push_back('{data: shadow[8'h11], last: 1'b1});
      @(negedge clk);
      total++;
      if (mem_ce !== 1'b1 || mem_addr !== 8'h10 || cmd_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_second got ce=%b addr=%h ready=%b, required 1 10 0", mem_ce, mem_addr, cmd_ready);
      end
      waitIdle();
   endtask

   initial begin
      test_reset();
`ifdef MEM_MASTER_INIT_CLEAR_EN
      test_init();
`endif
      test_single();
      test_wrap();
      test_bubble();
      test_reset_mid();
      test_back_to_back();
      waitIdle();
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL rsp_missing got %0d outstanding, required 0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
